// File: rtl/oam_port_arbiter.sv
// oam_port_arbiter
//   Owns the single primary-OAM port (256 x 8, combinational read, synchronous
//   write) and shares it between sprite evaluation, CPU $2003/$2004 accesses
//   and the $4014 OAM DMA engine. Holds the OAMADDR pointer and the DMA FSM.
//   Port priority: rendering > DMA > CPU. All state advances only on clk_en.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   clk_en                  PPU clock enable
//   rendering, ppu_rd_addr  sprite evaluation owns OAM / its read address
//   reg_addr_wr, reg_data_wr, reg_wdata, cpu_rdata   $2003/$2004 interface
//   dma_start, dma_page     $4014 trigger and source page
//   dma_re, dma_raddr, dma_rvalid, dma_rdata         DMA bus read interface
//   dma_busy                DMA in progress (stalls the CPU)
//   oam_addr, oam_we, oam_wdata, oam_rdata           OAM RAM port
module oam_port_arbiter #(
    parameter int DMA_LEN   = 256,
    parameter bit ATTR_MASK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        rendering,
    input  logic [7:0]  ppu_rd_addr,
    input  logic        reg_addr_wr,
    input  logic        reg_data_wr,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    output logic        dma_re,
    output logic [15:0] dma_raddr,
    input  logic        dma_rvalid,
    input  logic [7:0]  dma_rdata,
    output logic        dma_busy,
    output logic [7:0]  oam_addr,
    output logic        oam_we,
    output logic [7:0]  oam_wdata,
    input  logic [7:0]  oam_rdata
);

    typedef enum logic [2:0] {IDLE, ALIGN, READ, WAIT, WRITE} state_t;

    state_t     state;
    logic [7:0] ptr;
    logic [7:0] cnt;
    logic [7:0] page;
    logic [7:0] dbyte;     // byte fetched by DMA, waiting for its OAM slot
    logic       cpu_wr_ok;
    logic       dma_wr;
    logic       last_byte;
    logic [7:0] rd_view;

    // $2003 in the same cycle suppresses the $2004 write.
    assign cpu_wr_ok = reg_data_wr && !reg_addr_wr && !rendering && (state == IDLE);
    // DMA write is parked while rendering owns the port.
    assign dma_wr    = (state == WRITE) && !rendering;
    assign last_byte = (cnt == 8'(DMA_LEN - 1));

    assign oam_addr  = rendering ? ppu_rd_addr : ptr;
    assign oam_we    = clk_en && (dma_wr || cpu_wr_ok);
    assign oam_wdata = (state == WRITE) ? dbyte : reg_wdata;

    assign dma_re    = clk_en && (state == READ);
    assign dma_raddr = {page, cnt};
    assign dma_busy  = (state != IDLE);

    // Attribute bytes have no storage for bits [4:2]; they read back as 0.
    always_comb begin
        rd_view = oam_rdata;
        if (ATTR_MASK && !rendering && (ptr[1:0] == 2'd2))
            rd_view[4:2] = 3'b000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 8'd0;
            cnt       <= 8'd0;
            page      <= 8'd0;
            dbyte     <= 8'd0;
            cpu_rdata <= 8'd0;
        end else if (clk_en) begin
            cpu_rdata <= rd_view;

            // Pointer: $2003 always wins; a $2004 write during rendering
            // bumps the sprite index (+4) without touching ptr[1:0].
            if (reg_addr_wr)
                ptr <= reg_wdata;
            else if (reg_data_wr && rendering && (state == IDLE))
                ptr <= ptr + 8'd4;
            else if (cpu_wr_ok || dma_wr)
                ptr <= ptr + 8'd1;

            case (state)
                IDLE: begin
                    if (dma_start) begin
                        state <= ALIGN;
                        cnt   <= 8'd0;
                        page  <= dma_page;
                    end
                end
                ALIGN: state <= READ;
                READ:  state <= WAIT;
                WAIT: begin
                    if (dma_rvalid) begin
                        dbyte <= dma_rdata;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (!rendering) begin
                        if (last_byte) begin
                            state <= IDLE;
                        end else begin
                            cnt   <= cnt + 8'd1;
                            state <= READ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
